// File: rtl/playground_uart_pkg.sv
// Shared constants for the playground UART command front-end.
//   HDR_NIBBLE / SEL_*  : command header layout (A0..A3 selects the target)
//   ACK_NIBBLE/NAK_BYTE : bytes returned on the optional ack transmitter
//   RX_* / P_*          : state encodings for the receiver and the parser
package playground_uart_pkg;

    localparam logic [3:0] HDR_NIBBLE = 4'hA;

    localparam logic [1:0] SEL_MODE = 2'd0;
    localparam logic [1:0] SEL_UIHI = 2'd1;
    localparam logic [1:0] SEL_UIO  = 2'd2;
    localparam logic [1:0] SEL_RSV  = 2'd3;

    localparam logic [3:0] ACK_NIBBLE = 4'h5;
    localparam logic [7:0] NAK_BYTE   = 8'hEE;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [0:0] P_HDR  = 1'b0;
    localparam logic [0:0] P_DATA = 1'b1;

    // Header byte: upper nibble A, bits [3:2] zero, bits [1:0] select the target.
    function automatic logic is_header(input logic [7:0] b);
        return (b[7:4] == HDR_NIBBLE) && (b[3:2] == 2'b00);
    endfunction

endpackage

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver, LSB first, with a 2-flop input synchronizer.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   rx          : serial input, idle high, asynchronous to clk
//   data        : last received byte (valid while byte_valid is high)
//   byte_valid  : 1-cycle pulse when a byte with a good stop bit completes
//   frame_err   : 1-cycle pulse when the stop bit samples low (byte dropped)
module uart_rx_8n1 #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       frame_err
);
    import playground_uart_pkg::*;

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    logic [1:0]    sync;
    logic          rx_d;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    assign data = shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync       <= 2'b11;
            rx_d       <= 1'b1;
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync       <= {sync[0], rx};
            rx_d       <= sync[1];
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    // Edge (not level) detect: after a framing error the line may
                    // still be low when we get back here.
                    if (rx_d && !sync[1]) state <= RX_START;
                end
                RX_START: begin
                    if (cnt == HALF) begin
                        cnt   <= '0;
                        state <= sync[1] ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == FULL) begin
                        cnt   <= '0;
                        shift <= {sync[1], shift[7:1]};
                        if (bit_idx == 3'd7) state <= RX_STOP;
                        else                 bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin // RX_STOP
                    if (cnt == FULL) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                        if (sync[1]) byte_valid <= 1'b1;
                        else         frame_err  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/playground_uart_cmd.sv
// UART command front-end for the digital-playground core. Two-byte commands
// (header A0..A3, then data) write the mode, ui_hi or uio registers.
// Optional feature macro: ACK_TX_EN -- when defined, an 8N1 transmitter on tx
// answers each write with {5,00,sel} and each error with EE; otherwise tx=1.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   rx         : UART receive line
//   ui_drive   : {ui_hi[4:0], mode[2:0]} to core ui_in
//   uio_drive  : to core uio_in
//   cmd_strobe : 1-cycle pulse in the cycle a written value first appears
//   err        : 1-cycle pulse on framing error, bad header, reserved sel or timeout
//   tx         : ack line
module playground_uart_cmd #(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_CYC  = 2_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] ui_drive,
    output logic [7:0] uio_drive,
    output logic       cmd_strobe,
    output logic       err,
    output logic       tx
);
    import playground_uart_pkg::*;

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [7:0]    rx_data;
    logic          byte_valid;
    logic          frame_err;
    logic [0:0]    pstate;
    logic [1:0]    sel;
    logic [2:0]    mode;
    logic [4:0]    ui_hi;
    logic [7:0]    uio;
    logic [TW-1:0] to_cnt;
    logic          timeout;

    uart_rx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data       (rx_data),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    assign ui_drive  = {ui_hi, mode};
    assign uio_drive = uio;
    assign timeout   = (pstate == P_DATA) && (to_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pstate     <= P_HDR;
            sel        <= '0;
            mode       <= '0;
            ui_hi      <= '0;
            uio        <= '0;
            to_cnt     <= '0;
            cmd_strobe <= 1'b0;
            err        <= 1'b0;
        end else begin
            cmd_strobe <= 1'b0;
            err        <= 1'b0;
            if (pstate == P_HDR) begin
                if (frame_err) begin
                    err <= 1'b1;
                end else if (byte_valid) begin
                    if (is_header(rx_data)) begin
                        sel    <= rx_data[1:0];
                        pstate <= P_DATA;
                        to_cnt <= '0;
                    end else begin
                        err <= 1'b1;
                    end
                end
            end else begin
                to_cnt <= to_cnt + 1'b1;
                // Timeout wins over a byte finishing in the same cycle.
                if (timeout || frame_err) begin
                    err    <= 1'b1;
                    pstate <= P_HDR;
                end else if (byte_valid) begin
                    pstate <= P_HDR;
                    case (sel)
                        SEL_MODE: mode  <= rx_data[2:0];
                        SEL_UIHI: ui_hi <= rx_data[4:0];
                        SEL_UIO:  uio   <= rx_data;
                        default:  ;
                    endcase
                    cmd_strobe <= (sel != SEL_RSV);
                    err        <= (sel == SEL_RSV);
                end
            end
        end
    end

`ifdef ACK_TX_EN
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    logic          tx_busy;
    logic          tx_q;
    logic [8:0]    tx_sh;   // {stop, data}; ones shift in behind the data
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;

    assign tx = tx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_busy <= 1'b0;
            tx_q    <= 1'b1;
            tx_sh   <= '1;
            tx_cnt  <= '0;
            tx_bit  <= '0;
        end else if (!tx_busy) begin
            // Requests arriving while busy are simply never seen here.
            if (cmd_strobe || err) begin
                tx_busy <= 1'b1;
                tx_q    <= 1'b0;
                tx_sh   <= {1'b1, cmd_strobe ? {ACK_NIBBLE, 2'b00, sel} : NAK_BYTE};
                tx_cnt  <= '0;
                tx_bit  <= '0;
            end
        end else if (tx_cnt == FULL) begin
            tx_cnt <= '0;
            if (tx_bit == 4'd9) begin
                tx_busy <= 1'b0;
                tx_q    <= 1'b1;
            end else begin
                tx_q   <= tx_sh[0];
                tx_sh  <= {1'b1, tx_sh[8:1]};
                tx_bit <= tx_bit + 1'b1;
            end
        end else begin
            tx_cnt <= tx_cnt + 1'b1;
        end
    end
`else
    assign tx = 1'b1;
`endif

endmodule

// File: tb/tb_playground_uart_cmd.sv
// Bench for playground_uart_cmd: directed command vectors followed by random
// command streams, compared against a byte-level command model.
module tb_playground_uart_cmd;

    localparam int CPB = 16;
    localparam int TO  = 1000;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] ui_drive;
    logic [7:0] uio_drive;
    logic       cmd_strobe;
    logic       err;
    logic       tx;

    playground_uart_cmd #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYC(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .ui_drive   (ui_drive),
        .uio_drive  (uio_drive),
        .cmd_strobe (cmd_strobe),
        .err        (err),
        .tx         (tx)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse monitors.
    int          sc = 0, ec = 0, both = 0, bad_chg = 0;
    logic [15:0] prev;
    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_strobe) sc++;
            if (err) ec++;
            if (cmd_strobe && err) both++;
            if ({ui_drive, uio_drive} !== prev && !cmd_strobe) bad_chg++;
        end
        prev = {ui_drive, uio_drive};
    end

    // Reference model of the command layer.
    bit         m_pdata;
    logic [1:0] m_sel;
    logic [2:0] m_mode;
    logic [4:0] m_hi;
    logic [7:0] m_uio;
    int         e_sc = 0, e_ec = 0;
    logic [7:0] exp_tx[$];
    logic [7:0] got_tx[$];

    task automatic model_reset();
        m_pdata = 0; m_sel = 0; m_mode = 0; m_hi = 0; m_uio = 0;
    endtask

    task automatic model_err();
        e_ec++;
        exp_tx.push_back(8'hEE);
        m_pdata = 0;
    endtask

    task automatic model_byte(input logic [7:0] b, input bit ok);
        if (!ok) begin
            model_err();
        end else if (!m_pdata) begin
            if (b[7:4] == 4'hA && b[3:2] == 2'b00) begin
                m_pdata = 1;
                m_sel   = b[1:0];
            end else begin
                model_err();
            end
        end else begin
            m_pdata = 0;
            case (m_sel)
                2'd0: m_mode = b[2:0];
                2'd1: m_hi   = b[4:0];
                2'd2: m_uio  = b;
                default: ;
            endcase
            if (m_sel == 2'd3) model_err();
            else begin
                e_sc++;
                exp_tx.push_back({4'h5, 2'b00, m_sel});
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        rx = 1'b0;
        cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cyc(CPB);
        end
        rx = stop_ok;
        cyc(CPB);
        rx = 1'b1;
    endtask

    task automatic cmd_byte(input logic [7:0] b, input bit ok);
        send_byte(b, ok);
        model_byte(b, ok);
        cyc($urandom_range(4, 40));
    endtask

    task automatic idle_timeout();
        cyc(TO + 100);
        if (m_pdata) model_err();
    endtask

    task automatic glitch();
        rx = 1'b0;
        cyc(6);
        rx = 1'b1;
        cyc(30);
    endtask

    task automatic check_state(input string tag);
        cyc(4);
        chk({tag, "/ui"}, ui_drive, {m_hi, m_mode});
        chk({tag, "/uio"}, uio_drive, m_uio);
        chk({tag, "/strobes"}, sc, e_sc);
        chk({tag, "/errs"}, ec, e_ec);
`ifndef ACK_TX_EN
        chk({tag, "/tx"}, tx, 1'b1);
`endif
    endtask

`ifdef ACK_TX_EN
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                got_tx.push_back(b);
            end
        end
    end
`endif

    initial begin
        int k;
        rst = 1'b1;
        rx  = 1'b1;
        model_reset();
        cyc(5);
        chk("rst/ui", ui_drive, 8'h00);
        chk("rst/uio", uio_drive, 8'h00);
        chk("rst/strobe", cmd_strobe, 1'b0);
        chk("rst/err", err, 1'b0);
        chk("rst/tx", tx, 1'b1);
        rst = 1'b0;
        cyc(20);

        // Directed vectors.
        cmd_byte(8'hA0, 1); cmd_byte(8'h04, 1);
        check_state("t1");
        chk("t1/ui_const", ui_drive, 8'h04);

        cmd_byte(8'hA1, 1); cmd_byte(8'h1F, 1);
        cmd_byte(8'hA2, 1); cmd_byte(8'hAA, 1);
        check_state("t2");
        chk("t2/ui_const", ui_drive, 8'hFC);
        chk("t2/uio_const", uio_drive, 8'hAA);

        cmd_byte(8'h3C, 1);
        check_state("t3a");
        cmd_byte(8'hA0, 1); cmd_byte(8'h07, 1);
        check_state("t3b");
        chk("t3/mode_const", ui_drive[2:0], 3'b111);

        cmd_byte(8'hA2, 1);
        idle_timeout();
        check_state("t4a");
        cmd_byte(8'h55, 1);
        check_state("t4b");

        cmd_byte(8'h81, 0);
        check_state("t5a");
        glitch();
        check_state("t5b");

        cmd_byte(8'hA2, 1); cmd_byte(8'h5A, 1);
        cmd_byte(8'hA3, 1); cmd_byte(8'h00, 1);
        check_state("t6");

        // Random command streams.
        for (int it = 0; it < 30; it++) begin
            k = $urandom_range(0, 9);
            if (k <= 5) begin
                cmd_byte({4'hA, 2'b00, 2'($urandom_range(0, 3))}, 1);
                cmd_byte(8'($urandom), 1);
            end else if (k == 6) begin
                cmd_byte(8'($urandom), 1);
            end else if (k == 7) begin
                cmd_byte({4'hA, 2'b00, 2'($urandom_range(0, 3))}, 1);
                idle_timeout();
                cmd_byte(8'($urandom), 1);
            end else if (k == 8) begin
                if ($urandom_range(0, 1) == 1)
                    cmd_byte({4'hA, 2'b00, 2'($urandom_range(0, 3))}, 1);
                cmd_byte(8'($urandom), 0);
            end else begin
                glitch();
            end
            check_state($sformatf("rnd%0d", it));
        end

        // Reset in the middle of a byte.
        cmd_byte(8'hA1, 1); cmd_byte(8'h15, 1);
        check_state("pre_rst");
        cyc(200);
        rx = 1'b0;
        cyc(40);
        rst = 1'b1;
        rx  = 1'b1;
        #1;
        chk("mid_rst/ui", ui_drive, 8'h00);
        chk("mid_rst/uio", uio_drive, 8'h00);
        chk("mid_rst/strobe", cmd_strobe, 1'b0);
        chk("mid_rst/err", err, 1'b0);
        chk("mid_rst/tx", tx, 1'b1);
        model_reset();
        cyc(3);
        rst = 1'b0;
        cyc(10);
        cmd_byte(8'hA0, 1); cmd_byte(8'h03, 1);
        check_state("post_rst");
        chk("post_rst/ui_const", ui_drive, 8'h03);

        cyc(200);
        chk("strobe_err_overlap", both, 0);
        chk("change_without_strobe", bad_chg, 0);
`ifdef ACK_TX_EN
        chk("tx/count", got_tx.size(), exp_tx.size());
        for (int i = 0; i < got_tx.size() && i < exp_tx.size(); i++)
            chk($sformatf("tx/byte%0d", i), got_tx[i], exp_tx[i]);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
